// File: rtl/hh_pkg.sv
// Shared types and constants for the hh neuron stimulus/monitor slice.
package hh_pkg;

  localparam int unsigned VoltW = 16;
  localparam int unsigned CurW  = 16;

  localparam logic signed [VoltW-1:0] VThreshDefault = 16'sd4096;
  localparam logic signed [VoltW-1:0] VHystDefault   = 16'sd512;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StPulse,
    StPost,
    StDone
  } hh_state_e;

endpackage

// File: rtl/hh_stim_ctrl_if.sv
// Control, stimulus and spike-report signals between the I/O wrapper and hh_stim_ctrl.
interface hh_stim_ctrl_if;
  import hh_pkg::*;

  logic                    start;
  logic [7:0]              cfg_amp;
  logic [7:0]              cfg_width;
  logic signed [VoltW-1:0] v_in;
  logic [CurW-1:0]         current;
  logic                    busy;
  logic                    done;
  logic                    spike;
  logic [7:0]              spike_count;

  modport master (
    output start, cfg_amp, cfg_width, v_in,
    input  current, busy, done, spike, spike_count
  );

  modport slave (
    input  start, cfg_amp, cfg_width, v_in,
    output current, busy, done, spike, spike_count
  );

endinterface

// File: rtl/hh_spike_det.sv
// Threshold spike detector with hysteresis re-arm and a saturating per-run spike counter.
module hh_spike_det
  import hh_pkg::*;
#(
  parameter logic signed [VoltW-1:0] V_THRESH = VThreshDefault,
  parameter logic signed [VoltW-1:0] V_HYST   = VHystDefault
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic signed [VoltW-1:0] v_in,
  output logic                    spike,
  output logic [7:0]              spike_count
);

  // One extra bit so threshold minus hysteresis cannot wrap.
  localparam logic signed [VoltW:0] Rearm =
    $signed({V_THRESH[VoltW-1], V_THRESH}) - $signed({V_HYST[VoltW-1], V_HYST});

  logic       armed_q, armed_d;
  logic       spike_q, spike_d;
  logic [7:0] count_q, count_d;
  logic       hit;
  logic       below;

  assign hit   = enable && armed_q && (v_in >= V_THRESH);
  assign below = $signed({v_in[VoltW-1], v_in}) < Rearm;

  always_comb begin
    armed_d = armed_q;
    spike_d = hit;
    count_d = count_q;
    if (!enable) begin
      armed_d = 1'b1;
    end else if (hit) begin
      armed_d = 1'b0;
    end else if (!armed_q && below) begin
      armed_d = 1'b1;
    end
    if (clear) begin
      count_d = 8'd0;
    end else if (hit && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b1;
      spike_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      armed_q <= armed_d;
      spike_q <= spike_d;
      count_q <= count_d;
    end
  end

  assign spike       = spike_q;
  assign spike_count = count_q;

endmodule

// File: rtl/hh_stim_ctrl.sv
// Baseline/pulse/recovery current sequencer for the hh neuron, with spike monitoring of V_new.
module hh_stim_ctrl
  import hh_pkg::*;
#(
  parameter int unsigned             PRE_CYCLES  = 16,
  parameter int unsigned             POST_CYCLES = 64,
  parameter logic signed [VoltW-1:0] V_THRESH    = VThreshDefault,
  parameter logic signed [VoltW-1:0] V_HYST      = VHystDefault,
  parameter int unsigned             CUR_SHIFT   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  hh_stim_ctrl_if.slave bus
);

  localparam int unsigned   CntW     = 16;
  localparam logic [CntW-1:0] PreLoad  = CntW'(PRE_CYCLES - 1);
  localparam logic [CntW-1:0] PostLoad = CntW'(POST_CYCLES - 1);

  hh_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      amp_q, amp_d;
  logic [7:0]      width_q, width_d;
  logic [CurW-1:0] current_q, current_d;
  logic [CurW-1:0] amp_ext;
  logic            accept;
  logic            busy;

  assign accept  = (state_q == StIdle) && bus.start;
  assign amp_ext = {8'h00, amp_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StPre;
      StPre:   if (cnt_q == '0) state_d = StPulse;
      StPulse: if (cnt_q == '0) state_d = StPost;
      StPost:  if (cnt_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      StPre, StPulse, StPost: busy     = 1'b1;
      StDone:                 bus.done = 1'b1;
      default:                ;
    endcase
  end

  // Phase counter and captured configuration; width 0 wraps to a 256-cycle pulse.
  always_comb begin
    cnt_d   = cnt_q;
    amp_d   = amp_q;
    width_d = width_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          amp_d   = bus.cfg_amp;
          width_d = bus.cfg_width;
          cnt_d   = PreLoad;
        end
      end
      StPre:   cnt_d = (cnt_q == '0) ? {8'h00, width_q - 8'd1} : cnt_q - 1'b1;
      StPulse: cnt_d = (cnt_q == '0) ? PostLoad : cnt_q - 1'b1;
      StPost:  cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      default: cnt_d = '0;
    endcase
    current_d = (state_d == StPulse) ? (amp_ext << CUR_SHIFT) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      amp_q     <= 8'd0;
      width_q   <= 8'd0;
      current_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      amp_q     <= amp_d;
      width_q   <= width_d;
      current_q <= current_d;
    end
  end

  assign bus.current = current_q;
  assign bus.busy    = busy;

  hh_spike_det #(
    .V_THRESH (V_THRESH),
    .V_HYST   (V_HYST)
  ) u_spike_det (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (busy),
    .clear       (accept),
    .v_in        (bus.v_in),
    .spike       (bus.spike),
    .spike_count (bus.spike_count)
  );

endmodule

// File: tb/tb_hh_stim_ctrl.sv
// Self-checking bench for hh_stim_ctrl: two parameterisations, table-driven runs and random voltages.
module tb_hh_stim_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default timing; instance 1: short baseline, long recovery, shifted current.
  int pre_c  [2] = '{16, 3};
  int post_c [2] = '{64, 400};
  int sh_c   [2] = '{0, 4};

  logic               start0 = 1'b0;
  logic               start1 = 1'b0;
  logic [7:0]         amp = 8'd0;
  logic [7:0]         width = 8'd0;
  logic signed [15:0] v = 16'sd0;

  hh_stim_ctrl_if bus0();
  hh_stim_ctrl_if bus1();

  assign bus0.start     = start0;
  assign bus0.cfg_amp   = amp;
  assign bus0.cfg_width = width;
  assign bus0.v_in      = v;
  assign bus1.start     = start1;
  assign bus1.cfg_amp   = amp;
  assign bus1.cfg_width = width;
  assign bus1.v_in      = v;

  hh_stim_ctrl #(
    .PRE_CYCLES  (16),
    .POST_CYCLES (64),
    .CUR_SHIFT   (0)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  hh_stim_ctrl #(
    .PRE_CYCLES  (3),
    .POST_CYCLES (400),
    .CUR_SHIFT   (4)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic [15:0] cur_w  [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        spk_w  [2];
  logic [7:0]  cnt_w  [2];

  assign cur_w[0]  = bus0.current;
  assign busy_w[0] = bus0.busy;
  assign done_w[0] = bus0.done;
  assign spk_w[0]  = bus0.spike;
  assign cnt_w[0]  = bus0.spike_count;
  assign cur_w[1]  = bus1.current;
  assign busy_w[1] = bus1.busy;
  assign done_w[1] = bus1.done;
  assign spk_w[1]  = bus1.spike;
  assign cnt_w[1]  = bus1.spike_count;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_all(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s dut%0d current", tag, s), cur_w[s], 0);
      chk($sformatf("%s dut%0d busy", tag, s), busy_w[s], 0);
      chk($sformatf("%s dut%0d done", tag, s), done_w[s], 0);
      chk($sformatf("%s dut%0d spike", tag, s), spk_w[s], 0);
      chk($sformatf("%s dut%0d count", tag, s), cnt_w[s], 0);
    end
  endtask

  function automatic logic signed [15:0] pick_v(input int mode, input int k);
    logic signed [15:0] lvls [9];
    lvls = '{16'sd0, 16'sd3000, 16'sd3583, 16'sd3584, 16'sd3800,
             16'sd4095, 16'sd4096, 16'sd5000, 16'sh8000};
    case (mode)
      1: return lvls[$urandom_range(0, 8)];
      2: return (k == 2 || k == 3 || k == 5) ? 16'sd5000 : ((k == 4) ? 16'sd3000 : 16'sd0);
      3: return (k % 2 == 1) ? 16'sd5000 : 16'sd3800;
      4: return 16'sh8000;
      5: return (k % 2 == 1) ? 16'sd5000 : 16'sd0;
      default: return 16'sd0;
    endcase
  endfunction

  // Full run on one instance; expected outputs derive from the cycle index after start.
  task automatic run_check(input int sel, input logic [7:0] a, input logic [7:0] w,
                           input int mode, input int exp_cnt);
    int wd, n, pre, ecur, vi, cnt;
    bit armed, pend;
    wd    = (w == 8'd0) ? 256 : int'(w);
    pre   = pre_c[sel];
    n     = pre + wd + post_c[sel];
    ecur  = (int'(a) * (1 << sh_c[sel])) % 65536;
    armed = 1'b1;
    pend  = 1'b0;
    cnt   = 0;
    amp   = a;
    width = w;
    v     = 16'sd0;
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      chk($sformatf("dut%0d m%0d c%0d current", sel, mode, k), cur_w[sel],
          (k > pre && k <= pre + wd) ? ecur : 0);
      chk($sformatf("dut%0d m%0d c%0d busy", sel, mode, k), busy_w[sel], (k <= n) ? 1 : 0);
      chk($sformatf("dut%0d m%0d c%0d done", sel, mode, k), done_w[sel], (k == n + 1) ? 1 : 0);
      chk($sformatf("dut%0d m%0d c%0d spike", sel, mode, k), spk_w[sel], pend ? 1 : 0);
      chk($sformatf("dut%0d m%0d c%0d count", sel, mode, k), cnt_w[sel], cnt);
      // Starts and config changes while running must be ignored.
      if (k <= n + 1 && $urandom_range(0, 3) == 0) begin
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        amp   = 8'($urandom);
        width = 8'($urandom);
      end
      if (k <= n) begin
        v  = pick_v(mode, k);
        vi = int'(v);
        if (armed && vi >= 4096) begin
          pend  = 1'b1;
          armed = 1'b0;
          if (cnt < 255) cnt++;
        end else begin
          pend = 1'b0;
          if (!armed && vi < 3584) armed = 1'b1;
        end
      end else begin
        v    = 16'($urandom);
        pend = 1'b0;
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    v      = 16'sd0;
    if (exp_cnt >= 0) chk($sformatf("dut%0d m%0d final count", sel, mode), cnt_w[sel], exp_cnt);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] amp;
    logic [7:0] width;
    int         mode;
    int         exp_cnt;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{0, 8'h20, 8'd10, 0, 0};    // basic protocol, quiet neuron
    tbl[1] = '{0, 8'h33, 8'd0,  0, 0};    // width 0 -> 256-cycle pulse
    tbl[2] = '{1, 8'hFF, 8'd5,  0, 0};    // shifted current 0x0FF0
    tbl[3] = '{0, 8'h10, 8'd4,  2, 2};    // spike, re-arm below hysteresis, spike
    tbl[4] = '{0, 8'h11, 8'd8,  3, 1};    // oscillation above re-arm level
    tbl[5] = '{0, 8'h01, 8'd3,  4, 0};    // most negative voltage
    tbl[6] = '{1, 8'hFF, 8'd0,  5, 255};  // >255 crossings saturate
    tbl[7] = '{1, 8'h05, 8'd7,  0, 0};    // new start clears count
    tbl[8] = '{1, 8'hAB, 8'd2,  1, -1};

    amp = 8'd0;
    width = 8'd0;
    repeat (2) @(negedge clk);
    chk_idle_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_all("post-reset");

    // Reset mid-pulse after some spikes have been counted.
    amp    = 8'h40;
    width  = 8'd10;
    start0 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      v = (k % 2 == 1) ? 16'sd5000 : 16'sd0;
    end
    chk("mid-pulse current", cur_w[0], 16'h0040);
    chk("mid-pulse busy", busy_w[0], 1);
    chk("mid-pulse count", cnt_w[0], 10);
    rst_n = 1'b0;
    #1;
    chk("async reset current", cur_w[0], 0);
    chk("async reset busy", busy_w[0], 0);
    chk("async reset count", cnt_w[0], 0);
    chk("async reset spike", spk_w[0], 0);
    chk("async reset done", done_w[0], 0);
    v = 16'sd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset busy", busy_w[0], 0);
    chk("idle after reset current", cur_w[0], 0);

    foreach (tbl[i]) run_check(tbl[i].sel, tbl[i].amp, tbl[i].width, tbl[i].mode, tbl[i].exp_cnt);

    for (int r = 0; r < 6; r++) begin
      run_check(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(1, 40)), 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
